// File: rtl/trace_capture.sv
// Tracer-side endpoint of the trace-logger store/load protocol: packs parallel trace
// lanes into memory words in trace mode, replays logger words slice by slice in streaming mode.
module trace_capture #(
    parameter int TRB_WIDTH      = 32,
    parameter int TRB_MAX_TRACES = 8,
    localparam int CW = $clog2(TRB_WIDTH),
    localparam int NW = $clog2(TRB_MAX_TRACES)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      mode_i,
    input  logic [NW-1:0]             ntrace_i,
    input  logic                      en_i,
    input  logic [TRB_MAX_TRACES-1:0] trace_i,
    input  logic                      trg_i,
    input  logic                      trg_delayed_i,
    output logic                      trg_event_o,
    output logic [CW-1:0]             event_pos_o,
    output logic [TRB_WIDTH-1:0]      data_o,
    output logic                      store_o,
    output logic                      req_o,
    input  logic [TRB_WIDTH-1:0]      data_i,
    input  logic                      load_i,
    output logic [TRB_MAX_TRACES-1:0] stream_o,
    output logic                      stream_valid_o,
    input  logic                      stream_ready_i,
    output logic                      done_o
);

    localparam int          LW     = CW + 1;
    localparam logic [NW-1:0] LG_MAX = NW'(NW);

    typedef enum logic [2:0] {
        CAPTURE = 3'd0,
        DRAIN   = 3'd1,
        HALT    = 3'd2,
        S_REQ   = 3'd3,
        S_WAIT  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t                      state_r, state_n;
    logic                        mode_r;
    logic [NW-1:0]               ntrace_r, ntrace_n;
    logic [CW-1:0]               cnt_r, cnt_n;
    logic [TRB_WIDTH-1:0]        word_r, word_n;
    logic [TRB_WIDTH-1:0]        buf_r, buf_n;
    logic [TRB_WIDTH-1:0]        data_r, data_n;
    logic                        store_r, store_n;
    logic                        req_r, req_n;
    logic                        trg_r, trg_n;
    logic [CW-1:0]               pos_r, pos_n;
    logic                        done_r;
    logic                        valid_r;

    logic [NW-1:0]               lg_raw_s, lg_s;
    logic [LW-1:0]               lanes_s;
    logic [TRB_MAX_TRACES-1:0]   mask_s;
    logic [CW-1:0]               last_s;
    logic [TRB_WIDTH-1:0]        ins_s, shifted_s;
    logic                        take_s, complete_s;

    // Lane geometry: the first sample of a word (counter 0) uses the live lane select,
    // later samples and the whole stream replay use the latched one.
    always_comb begin
        lg_raw_s   = ((cnt_r == '0) && (state_r != S_OUT)) ? ntrace_i : ntrace_r;
        lg_s       = (lg_raw_s > LG_MAX) ? LG_MAX : lg_raw_s;
        lanes_s    = LW'(1) << lg_s;
        mask_s     = ~({TRB_MAX_TRACES{1'b1}} << lanes_s);
        last_s     = CW'((TRB_WIDTH >> lg_s) - 1);
        ins_s      = TRB_WIDTH'(trace_i & mask_s) << (TRB_WIDTH - int'(lanes_s));
        shifted_s  = (word_r >> lanes_s) | ins_s;
        take_s     = en_i && ((state_r == CAPTURE) || (state_r == DRAIN));
        complete_s = take_s && (cnt_r == last_s);
    end

    // Next-state and datapath update for both capture and streaming.
    always_comb begin
        state_n  = state_r;
        ntrace_n = ((cnt_r == '0) && (state_r != S_OUT)) ? ntrace_i : ntrace_r;
        cnt_n    = cnt_r;
        word_n   = word_r;
        buf_n    = buf_r;
        data_n   = data_r;
        store_n  = 1'b0;
        req_n    = 1'b0;
        trg_n    = trg_r;
        pos_n    = pos_r;

        if (mode_i != mode_r) begin
            // A mode switch discards all in-flight work and the trigger record.
            state_n = mode_i ? S_REQ : CAPTURE;
            cnt_n   = '0;
            word_n  = '0;
            buf_n   = '0;
            data_n  = '0;
            trg_n   = 1'b0;
            pos_n   = '0;
        end else begin
            case (state_r)
                CAPTURE, DRAIN: begin
                    if (take_s) begin
                        word_n = shifted_s;
                        if (complete_s) begin
                            cnt_n   = '0;
                            data_n  = shifted_s;
                            store_n = 1'b1;
                        end else begin
                            cnt_n = cnt_r + CW'(1);
                        end
                    end else begin
                        word_n = word_r;
                    end
                    if (take_s && trg_i && !trg_r) begin
                        trg_n = 1'b1;
                        pos_n = CW'(cnt_r << lg_s);
                    end else begin
                        trg_n = trg_r;
                    end
                    if (complete_s && ((state_r == DRAIN) || trg_delayed_i)) begin
                        state_n = HALT;
                    end else if ((state_r == CAPTURE) && trg_delayed_i) begin
                        state_n = (cnt_r == '0) ? HALT : DRAIN;
                    end else begin
                        state_n = state_r;
                    end
                end
                HALT: begin
                    state_n = HALT;
                end
                S_REQ: begin
                    req_n   = 1'b1;
                    state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (load_i) begin
                        buf_n   = data_i;
                        cnt_n   = '0;
                        state_n = S_OUT;
                    end else begin
                        state_n = S_WAIT;
                    end
                end
                S_OUT: begin
                    if (stream_ready_i) begin
                        buf_n = buf_r >> lanes_s;
                        if (cnt_r == last_s) begin
                            cnt_n   = '0;
                            state_n = S_REQ;
                        end else begin
                            cnt_n = cnt_r + CW'(1);
                        end
                    end else begin
                        buf_n = buf_r;
                    end
                end
                default: begin
                    state_n = CAPTURE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= CAPTURE;
        end else begin
            state_r <= state_n;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_r   <= 1'b0;
            ntrace_r <= '0;
            cnt_r    <= '0;
            word_r   <= '0;
            buf_r    <= '0;
            data_r   <= '0;
            store_r  <= 1'b0;
            req_r    <= 1'b0;
            trg_r    <= 1'b0;
            pos_r    <= '0;
            done_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            mode_r   <= mode_i;
            ntrace_r <= ntrace_n;
            cnt_r    <= cnt_n;
            word_r   <= word_n;
            buf_r    <= buf_n;
            data_r   <= data_n;
            store_r  <= store_n;
            req_r    <= req_n;
            trg_r    <= trg_n;
            pos_r    <= pos_n;
            done_r   <= (state_n == HALT);
            valid_r  <= (state_n == S_OUT);
        end
    end

    assign trg_event_o    = trg_r;
    assign event_pos_o    = pos_r;
    assign data_o         = data_r;
    assign store_o        = store_r;
    assign req_o          = req_r;
    assign done_o         = done_r;
    assign stream_valid_o = valid_r;
    assign stream_o       = valid_r ? (buf_r[TRB_MAX_TRACES-1:0] & mask_s) : '0;

endmodule

// File: tb/tb_trace_capture.sv
// Randomized scoreboard bench for trace_capture: a sample-list reference model predicts
// stored words, trigger record and stream slices; a negedge monitor compares them.
module tb_trace_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode = 1'b0;
    logic [2:0]  ntrace = 3'd0;
    logic        en = 1'b0;
    logic [7:0]  trace = 8'd0;
    logic        trg = 1'b0;
    logic        tdel = 1'b0;
    logic        trg_event;
    logic [4:0]  event_pos;
    logic [31:0] data;
    logic        store;
    logic        req;
    logic [31:0] din = 32'd0;
    logic        load = 1'b0;
    logic [7:0]  stream;
    logic        svalid;
    logic        ready = 1'b0;
    logic        done;

    always #5 clk = ~clk;

    trace_capture #(.TRB_WIDTH(32), .TRB_MAX_TRACES(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .ntrace_i(ntrace), .en_i(en),
        .trace_i(trace), .trg_i(trg), .trg_delayed_i(tdel), .trg_event_o(trg_event),
        .event_pos_o(event_pos), .data_o(data), .store_o(store), .req_o(req),
        .data_i(din), .load_i(load), .stream_o(stream), .stream_valid_o(svalid),
        .stream_ready_i(ready), .done_o(done)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;
    logic [31:0] q_store[$];
    logic [7:0]  q_stream[$];

    // Reference model state (sample-list view of the current word).
    int          m_cnt = 0;
    int          m_L = 1;
    logic [31:0] m_acc = 32'd0;
    bit          m_halt = 1'b0;
    bit          m_drain = 1'b0;
    logic        nx_trg = 1'b0, ex_trg = 1'b0;
    logic        nx_done = 1'b0, ex_done = 1'b0;
    logic [4:0]  nx_pos = 5'd0, ex_pos = 5'd0;

    function automatic int lanes(input logic [2:0] n);
        if (n >= 3'd3) return 8;
        else return 1 << n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ex_trg  = nx_trg;
        ex_pos  = nx_pos;
        ex_done = nx_done;
    endtask

    task automatic model_clear();
        m_cnt = 0; m_acc = 32'd0; m_halt = 1'b0; m_drain = 1'b0;
        nx_trg = 1'b0; nx_pos = 5'd0; nx_done = 1'b0;
        ex_trg = 1'b0; ex_pos = 5'd0; ex_done = 1'b0;
    endtask

    // One capture-mode cycle: drive inputs, advance the model, clock.
    task automatic cap(input bit e, input logic [7:0] tr, input bit tg, input bit td);
        int  cb;
        bit  comp;
        en = e; trace = tr; trg = tg; tdel = td;
        cb = m_cnt;
        comp = 1'b0;
        if (!m_halt && e) begin
            if (m_cnt == 0) m_L = lanes(ntrace);
            m_acc = m_acc | (32'(tr & 8'((1 << m_L) - 1)) << (m_cnt * m_L));
            if (tg && !nx_trg) begin
                nx_trg = 1'b1;
                nx_pos = 5'(m_cnt * m_L);
            end
            m_cnt++;
            if (m_cnt == 32 / m_L) begin
                q_store.push_back(m_acc);
                m_acc = 32'd0;
                m_cnt = 0;
                comp = 1'b1;
            end
        end
        if (!m_halt) begin
            if (m_drain) begin
                if (comp) m_halt = 1'b1;
            end else if (td) begin
                if (comp || cb == 0) m_halt = 1'b1;
                else m_drain = 1'b1;
            end
        end
        if (m_halt) nx_done = 1'b1;
        step();
        en = 1'b0; trg = 1'b0; tdel = 1'b0;
    endtask

    task automatic do_reset();
        mon_on = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_data", data, 32'd0);
        chk("rst_store", 32'(store), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_trg", 32'(trg_event), 32'd0);
        chk("rst_pos", 32'(event_pos), 32'd0);
        chk("rst_svalid", 32'(svalid), 32'd0);
        chk("rst_stream", 32'(stream), 32'd0);
        model_clear();
        q_store.delete();
        q_stream.delete();
        en = 1'b0; trg = 1'b0; tdel = 1'b0; load = 1'b0; ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mon_on = 1'b1;
    endtask

    task automatic set_mode(input logic m);
        mode = m; en = 1'b0; ready = 1'b0; load = 1'b0; trg = 1'b0; tdel = 1'b0;
        step();
        q_stream.delete();
        model_clear();
    endtask

    // One streamed word: wait for REQ, play logger, drain slices (abort < 0 means run to end).
    task automatic stream_word(input logic [31:0] d, input logic [2:0] nt,
                               input int hold_slice, input int hold_n, input int abort);
        int t, L, rem, k, held, guard;
        ntrace = nt;
        L = lanes(nt);
        t = 0;
        while (req !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        if (t >= 20) begin
            chk("req_timeout", 32'(req), 32'd1);
            return;
        end
        step();
        chk("req_pulse", 32'(req), 32'd0);
        repeat ($urandom_range(0, 1)) step();
        load = 1'b1;
        din = d;
        for (int i = 0; i < 32 / L; i++) q_stream.push_back(8'((d >> (i * L)) & ((1 << L) - 1)));
        step();
        load = 1'b0;
        chk("first_valid", 32'(svalid), 32'd1);
        rem = 32 / L; k = 0; held = 0; guard = 0;
        while (rem > 0 && guard < 300) begin
            if (abort >= 0 && k == abort) break;
            if (k == hold_slice && held < hold_n) begin
                ready = 1'b0;
                held++;
            end else begin
                ready = ($urandom_range(0, 3) != 0);
            end
            load = ($urandom_range(0, 7) == 0);
            din = $urandom;
            if (ready) begin
                rem--;
                k++;
            end
            step();
            guard++;
        end
        ready = 1'b0;
        load = 1'b0;
        if (guard >= 300) chk("stream_timeout", 32'(rem), 32'd0);
        if (abort < 0) begin
            chk("req_gap_low", 32'(req), 32'd0);
            step();
            chk("req_after_word", 32'(req), 32'd1);
        end
    endtask

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("trg_event", 32'(trg_event), 32'(ex_trg));
            chk("event_pos", 32'(event_pos), 32'(ex_pos));
            chk("done", 32'(done), 32'(ex_done));
            if (store) begin
                if (q_store.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL store_extra: got %h expected no store at %0t", data, $time);
                end else begin
                    chk("store_data", data, q_store.pop_front());
                end
            end
            if (svalid) begin
                if (q_stream.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL stream_extra: got %h expected no slice at %0t", stream, $time);
                end else begin
                    chk("stream_slice", 32'(stream), 32'(q_stream[0]));
                    if (ready) void'(q_stream.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        ntrace = 3'd3;
        for (int i = 0; i < 8; i++) cap(1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);

        ntrace = 3'd0;
        for (int i = 0; i < 32; i++) cap(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) cap(1'b1, 8'($urandom), (i == 5) || (i == 20), 1'b0);

        ntrace = 3'd3;
        for (int i = 0; i < 2; i++) cap(1'b1, 8'($urandom), 1'b0, 1'b0);
        ntrace = 3'd0;
        for (int i = 0; i < 34; i++) cap(1'b1, 8'($urandom), 1'b0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            ntrace = 3'($urandom_range(0, 7));
            cap($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0, 1'b0);
        end

        do_reset();
        ntrace = 3'd3;
        for (int i = 0; i < 2; i++) cap(1'b1, 8'($urandom), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) cap(1'b1, 8'($urandom), 1'b0, 1'b0);

        for (int i = 0; i < 2; i++) cap(1'b1, 8'($urandom), 1'b0, 1'b0);
        cap(1'b0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cap(1'b1, 8'($urandom), 1'b0, 1'b0);

        do_reset();
        cap(1'b0, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cap(1'b1, 8'($urandom), 1'b0, 1'b0);

        do_reset();
        for (int i = 0; i < 3; i++) cap(1'b1, 8'($urandom), 1'b0, 1'b0);
        cap(1'b1, 8'($urandom), 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cap(1'b1, 8'($urandom), 1'b0, 1'b0);

        do_reset();
        cap(1'b1, 8'($urandom), 1'b1, 1'b0);
        cap(1'b1, 8'($urandom), 1'b0, 1'b0);
        set_mode(1'b1);

        stream_word(32'hA1B2C3D4, 3'd3, 1, 3, -1);
        for (int i = 0; i < 6; i++) stream_word($urandom, 3'($urandom_range(0, 7)), -1, 0, -1);
        stream_word($urandom, 3'd3, -1, 0, 2);
        set_mode(1'b0);
        chk("toggle_svalid", 32'(svalid), 32'd0);
        chk("toggle_stream", 32'(stream), 32'd0);
        chk("toggle_trg", 32'(trg_event), 32'd0);

        ntrace = 3'd3;
        for (int i = 0; i < 8; i++) cap(1'b1, 8'($urandom), i == 6, 1'b0);
        step();

        chk("store_queue_empty", 32'(q_store.size()), 32'd0);
        chk("stream_queue_empty", 32'(q_stream.size()), 32'd0);
        mon_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
